// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size encodings, Nk/Nr lookup, S-box and xtime.
package aes_pkg;

  typedef enum logic [1:0] {
    KS_128 = 2'b00,
    KS_192 = 2'b01,
    KS_256 = 2'b10,
    KS_BAD = 2'b11
  } key_size_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [3:0] nk_of(input logic [1:0] ks);
    case (ks)
      KS_192:  return 4'd6;
      KS_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    case (ks)
      KS_192:  return 4'd12;
      KS_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  always_comb begin
    dout = '0;
    for (int unsigned b = 0; b < 4; b++)
      dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128/192/256 key schedule: one word per cycle through a shared
// SubWord unit, stored in a word file and served as registered round keys.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 60
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iStart,
  input  logic [1:0]   iKeySize,
  input  logic [255:0] iKey,
  input  logic [3:0]   iRkIdx,
  output logic [127:0] oRoundKey,
  output logic [3:0]   oNr,
  output logic         oBusy,
  output logic         oKeyValid,
  output logic         oErr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } state_e;

  state_e      state;
  logic [31:0] wfile [MAX_WORDS];
  logic [5:0]  widx;
  logic [2:0]  wmod;
  logic [3:0]  nk;
  logic [7:0]  rcon;

  logic        start_ok, accept, bad_req;
  logic [5:0]  wend, rbase;
  logic [31:0] temp, wback, sub_in, sub_out, fword, wnew;

  assign start_ok = iStart && (state == ST_IDLE || state == ST_DONE);
  assign accept   = start_ok && (iKeySize != KS_BAD);
  assign bad_req  = start_ok && (iKeySize == KS_BAD);
  assign wend     = {oNr, 2'b00} + 6'd4;
  assign rbase    = (iRkIdx <= oNr) ? {iRkIdx, 2'b00} : '0;

  assign temp   = wfile[widx - 6'd1];
  assign wback  = wfile[widx - {2'b00, nk}];
  assign sub_in = (wmod == '0) ? {temp[23:0], temp[31:24]} : temp;

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    fword = temp;
    if (wmod == '0)
      fword = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && wmod == 3'd4)
      fword = sub_out;
    wnew = wback ^ fword;
  end

  // EXPAND spends one extra cycle at widx==wend so oKeyValid rises the edge after the last write.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state     <= ST_IDLE;
      widx      <= '0;
      wmod      <= '0;
      nk        <= 4'd4;
      rcon      <= 8'h01;
      oNr       <= '0;
      oBusy     <= 1'b0;
      oKeyValid <= 1'b0;
      oErr      <= 1'b0;
      oRoundKey <= '0;
    end else begin
      oErr <= bad_req;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            nk        <= nk_of(iKeySize);
            oNr       <= nr_of(iKeySize);
            widx      <= {2'b00, nk_of(iKeySize)};
            wmod      <= '0;
            rcon      <= 8'h01;
            oBusy     <= 1'b1;
            oKeyValid <= 1'b0;
            state     <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (widx == wend) begin
            oBusy     <= 1'b0;
            oKeyValid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            widx <= widx + 6'd1;
            wmod <= (wmod == 3'(nk - 4'd1)) ? '0 : wmod + 3'd1;
            if (wmod == '0)
              rcon <= xtime(rcon);
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A restart in the same cycle hides the read, matching oKeyValid dropping.
      if (oKeyValid && !accept && iRkIdx <= oNr)
        oRoundKey <= {wfile[rbase], wfile[rbase + 6'd1], wfile[rbase + 6'd2], wfile[rbase + 6'd3]};
      else
        oRoundKey <= '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst_n) begin
      if (accept) begin
        for (int unsigned k = 0; k < 8; k++)
          if (k < 32'(nk_of(iKeySize)))
            wfile[6'(k)] <= iKey[255 - 32*k -: 32];
      end else if (state == ST_EXPAND && widx != wend) begin
        wfile[widx] <= wnew;
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using FIPS-197 key expansion vectors.
module tb_key_schedule_ctrl;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         iClk = 1'b0;
  logic         iRst_n, iStart;
  logic [1:0]   iKeySize;
  logic [255:0] iKey;
  logic [3:0]   iRkIdx;
  logic [127:0] oRoundKey;
  logic [3:0]   oNr;
  logic         oBusy, oKeyValid, oErr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edges    = 0;
  int unsigned t0       = 0;

  always #5 iClk = ~iClk;
  always @(posedge iClk) edges <= edges + 1;

  key_schedule_ctrl #(.MAX_WORDS(60)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iStart    (iStart),
    .iKeySize  (iKeySize),
    .iKey      (iKey),
    .iRkIdx    (iRkIdx),
    .oRoundKey (oRoundKey),
    .oNr       (oNr),
    .oBusy     (oBusy),
    .oKeyValid (oKeyValid),
    .oErr      (oErr)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pulse iStart across one edge; t0 marks that edge.
  task automatic kick(input logic [1:0] ks, input logic [255:0] key);
    @(negedge iClk);
    iKeySize = ks;
    iKey     = key;
    iStart   = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    t0     = edges;
  endtask

  task automatic wait_valid(input string tag, input int unsigned exp_cyc);
    while (!oKeyValid && (edges - t0) < 200) @(negedge iClk);
    check(tag, 128'(edges - t0), 128'(exp_cyc));
  endtask

  task automatic read_rk(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    iRkIdx = idx;
    @(negedge iClk);
    check(tag, oRoundKey, exp);
  endtask

  initial begin
    iRst_n = 1'b0; iStart = 1'b0; iKeySize = 2'b00; iKey = '0; iRkIdx = '0;
    repeat (3) @(negedge iClk);
    iRst_n = 1'b1;
    check("rst_rk",    oRoundKey, '0);
    check("rst_nr",    128'(oNr), 128'd0);
    check("rst_busy",  128'(oBusy), 128'd0);
    check("rst_valid", 128'(oKeyValid), 128'd0);
    check("rst_err",   128'(oErr), 128'd0);

    // illegal size from IDLE
    kick(2'b11, K128);
    check("bad_idle_err",   128'(oErr), 128'd1);
    check("bad_idle_busy",  128'(oBusy), 128'd0);
    check("bad_idle_valid", 128'(oKeyValid), 128'd0);
    @(negedge iClk);
    check("bad_idle_err_pulse", 128'(oErr), 128'd0);
    check("bad_idle_busy2",     128'(oBusy), 128'd0);

    // AES-128 with a second start mid-expansion that must be ignored
    kick(2'b00, K128);
    check("a128_busy", 128'(oBusy), 128'd1);
    repeat (19) @(negedge iClk);
    iKeySize = 2'b10; iKey = K256; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    check("a128_restart_busy", 128'(oBusy), 128'd1);
    check("a128_restart_err",  128'(oErr), 128'd0);
    wait_valid("a128_lat", 41);
    check("a128_nr",   128'(oNr), 128'd10);
    check("a128_busy_done", 128'(oBusy), 128'd0);
    read_rk("a128_rk0",  4'd0,  128'h000102030405060708090a0b0c0d0e0f);
    read_rk("a128_rk1",  4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    read_rk("a128_rk10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    read_rk("a128_rk11", 4'd11, '0);

    // illegal size from DONE keeps schedule
    kick(2'b11, K256);
    check("bad_done_err",   128'(oErr), 128'd1);
    check("bad_done_valid", 128'(oKeyValid), 128'd1);
    read_rk("bad_done_rk10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("bad_done_err_pulse", 128'(oErr), 128'd0);

    // AES-192
    kick(2'b01, K192);
    wait_valid("a192_lat", 47);
    check("a192_nr", 128'(oNr), 128'd12);
    read_rk("a192_rk1",  4'd1,  128'h10111213141516175846f2f95c43f4fe);
    read_rk("a192_rk12", 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d);
    read_rk("a192_rk13", 4'd13, '0);

    // AES-256
    kick(2'b10, K256);
    wait_valid("a256_lat", 53);
    check("a256_nr", 128'(oNr), 128'd14);
    read_rk("a256_rk1",  4'd1,  128'h101112131415161718191a1b1c1d1e1f);
    read_rk("a256_rk2",  4'd2,  128'ha573c29fa176c498a97fce93a572c09c);
    read_rk("a256_rk14", 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // restart from DONE while reading: that read returns 0
    iRkIdx = 4'd1;
    kick(2'b00, K128);
    check("sim_rk",    oRoundKey, '0);
    check("sim_valid", 128'(oKeyValid), 128'd0);
    check("sim_busy",  128'(oBusy), 128'd1);
    wait_valid("sim_lat", 41);
    read_rk("sim_rk1", 4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);

    // reset mid-expansion, then AES-256
    iRkIdx = 4'd2;
    kick(2'b00, K128);
    repeat (9) @(negedge iClk);
    iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    check("mrst_valid", 128'(oKeyValid), 128'd0);
    check("mrst_busy",  128'(oBusy), 128'd0);
    check("mrst_rk",    oRoundKey, '0);
    check("mrst_nr",    128'(oNr), 128'd0);
    repeat (3) @(negedge iClk);
    check("mrst_valid_hold", 128'(oKeyValid), 128'd0);
    kick(2'b10, K256);
    wait_valid("mrst_a256_lat", 53);
    read_rk("mrst_a256_rk2",  4'd2,  128'ha573c29fa176c498a97fce93a572c09c);
    read_rk("mrst_a256_rk14", 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    read_rk("mrst_a256_rk15", 4'd15, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
- Iterative, resource-shared AES key schedule controller for AES-128/192/256.
- Loads a cipher key on a start pulse and generates one 32-bit schedule word per cycle using a single SubWord unit.
- Stores the full schedule in an internal word file and serves round keys to the round-iterative cipher core through an indexed, registered read port.
- Replaces the fully unrolled combinational expansion where area matters.

Parameters:
- MAX_WORDS, 60, depth of the word file (4*(14+1), sized for AES-256).

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  synchronous reset, active-low.
- iStart  in  1  start-expansion pulse; sampled only in IDLE or DONE.
- iKeySize  in  2  key size: 00=128, 01=192, 10=256, 11=illegal.
- iKey  in  256  cipher key, MSB-aligned. 128-bit keys use [255:128]; 192-bit keys use [255:64].
- iRkIdx  in  4  round-key index, 0..Nr.
- oRoundKey  out  128  round key iRkIdx, registered, {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
- oNr  out  4  round count of the loaded key: 10, 12 or 14; 0 after reset.
- oBusy  out  1  expansion in progress.
- oKeyValid  out  1  schedule complete and readable.
- oErr  out  1  one-cycle pulse when iStart is issued with iKeySize=11.

Behaviour:
- Reset (iRst_n=0 at a clock edge):
  - State goes to IDLE.
  - oRoundKey=0, oNr=0, oBusy=0, oKeyValid=0, oErr=0.
  - Rcon register = 8'h01.
  - Word-file contents need not be cleared.
  - Reset mid-expansion aborts it; oKeyValid stays 0.
- States:
  - IDLE:
    - iStart with a legal size: load words w[0..Nk-1] from iKey in one cycle, latch Nk (4/6/8) and Nr (10/12/14), set word counter i=Nk, set Rcon=01, set oBusy=1, go to EXPAND.
    - iStart with size 11: pulse oErr and stay in IDLE.
  - EXPAND:
    - Each cycle, temp=w[i-1] and compute w[i]=w[i-Nk]^f(temp), where:
      - i mod Nk==0: f = SubWord(RotWord(temp))^{Rcon,24'h0}, then Rcon <= xtime(Rcon).
      - Nk==8 and i mod 8==4: f = SubWord(temp).
      - otherwise: f = temp.
    - i increments by 1 per cycle. Track i mod Nk with a wrapping counter; no divider.
    - After writing word 4*(Nr+1)-1, go to DONE: oBusy=0, oKeyValid=1.
    - iStart is ignored while in EXPAND.
  - DONE:
    - Read port is active.
    - iStart (legal size) restarts exactly as from IDLE and clears oKeyValid in the same cycle oBusy rises.
    - iStart with size 11 pulses oErr and keeps the current schedule valid.
- Latency:
  - iStart sampled at edge 0; oKeyValid=1 after edge 1+(4(Nr+1)-Nk).
  - That is 41 cycles for AES-128, 47 for AES-192, 53 for AES-256.
- Read port:
  - oRoundKey updates one cycle after iRkIdx every cycle.
  - Output is 0 when oKeyValid=0 or iRkIdx>oNr.
- Arithmetic:
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
  - All word ops are 32-bit XOR; word 0 is key bits [255:224].
- Simultaneous iStart with an iRkIdx read in DONE: the read in that cycle returns 0, because oKeyValid is cleared.

Decomposition:
- Shared package aes_pkg:
  - key-size encodings;
  - Nk/Nr lookup functions;
  - the S-box function;
  - xtime function.
- Sub-module aes_subword: four combinational S-box lookups on a 32-bit word. It is the single SubWord instance shared across all iterations and is reusable by the cipher core's SubBytes.

Test Plan:
- AES-128, key 000102030405060708090a0b0c0d0e0f, start:
  - oKeyValid rises exactly 41 cycles after start; oNr=10.
  - RK1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
  - RK10 = 13111d7fe3944a17f307a78b4d2b30c5.
- AES-192, key 000102...1617:
  - valid after 47 cycles; oNr=12.
  - RK1 = 10111213141516175846f2f95c43f4fe.
  - RK12 = a4970a331a78dc09c418c271e3a41d5d.
- AES-256, key 000102...1e1f:
  - valid after 53 cycles; oNr=14.
  - RK2 = a573c29fa176c498a97fce93a572c09c.
  - RK14 = 24fc79ccbf0979e9371ac23c6d68de36.
- iStart with iKeySize=11 in IDLE:
  - oErr pulses for one cycle; oBusy stays 0; oKeyValid stays 0.
- Second iStart at cycle 20 of an AES-128 expansion:
  - ignored; results identical to the first test.
- iRst_n low for one cycle mid-expansion (cycle 10), then AES-256 start:
  - oKeyValid=0 after reset; oRoundKey=0.
  - Fresh expansion matches the AES-256 golden values.
  - Reading iRkIdx=15 returns 0.
